// File: rtl/snake_sprite_pkg.sv
// snake_sprite_pkg: orientation types, RGB565 colour key and bank address helper.
package snake_sprite_pkg;
    typedef enum logic [1:0] {ROT0, ROT90, ROT180, ROT270} rot_t;
    typedef struct packed {
        logic mirror;
        rot_t rot;
    } orient_t;
    localparam logic [15:0] RGB565_TRANSPARENT = 16'hF81F;
    function automatic logic [31:0] sprite_addr(input logic [31:0] sprite, input logic [31:0] x,
                                                input logic [31:0] y, input int cw);
        return (sprite << (2 * cw)) | (y << cw) | x;
    endfunction
endpackage

// File: rtl/snake_sprite_orient.sv
// snake_sprite_orient: maps a displayed (x, y) to the stored source pixel for a rotation/mirror.
module snake_sprite_orient
    import snake_sprite_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [2:0]    orient,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy
);
    orient_t       o;
    logic [CW-1:0] mx;
    // D-1-v is the bitwise complement because D is a power of two
    always_comb begin
        o  = orient_t'(orient);
        mx = o.mirror ? ~x : x;
        sx = (o.rot == ROT0) ? mx : (o.rot == ROT90) ? y : (o.rot == ROT180) ? ~mx : ~y;
        sy = (o.rot == ROT0) ? y : (o.rot == ROT90) ? ~mx : (o.rot == ROT180) ? ~y : mx;
    end
endmodule

// File: rtl/snake_sprite_bank.sv
// snake_sprite_bank: multi-sprite pixel RAM with Avalon-MM host port and pipelined render read port.
// Define SNAKE_SPRITE_ORIENT_EN to enable per-request rotation/mirroring of render fetches.
module snake_sprite_bank
    import snake_sprite_pkg::*;
#(
    parameter int                NUM_SPRITES = 8,
    parameter int                SPRITE_DIM  = 16,
    parameter int                PIX_W       = 16,
    parameter logic [PIX_W-1:0]  TRANSPARENT = PIX_W'(RGB565_TRANSPARENT),
    parameter                    INIT_FILE   = "",
    localparam int               CW          = $clog2(SPRITE_DIM),
    localparam int               SW          = $clog2(NUM_SPRITES),
    localparam int               AW          = SW + 2 * CW,
    localparam int               BW          = PIX_W / 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic             write,
    input  logic             read,
    input  logic [AW-1:0]    address,
    input  logic [BW-1:0]    byteenable,
    input  logic [PIX_W-1:0] writedata,
    output logic             waitrequest,
    output logic [PIX_W-1:0] readdata,
    output logic             readdatavalid,
    input  logic             rd_req,
    input  logic [SW-1:0]    rd_sprite,
    input  logic [CW-1:0]    rd_x,
    input  logic [CW-1:0]    rd_y,
    input  logic [2:0]       rd_orient,
    output logic             rd_valid,
    output logic [PIX_W-1:0] rd_pixel,
    output logic             rd_opaque
);
    logic [PIX_W-1:0] mem [2**AW];
    logic [CW-1:0]    sx, sy;
    logic [31:0]      render_wide;
    logic [AW-1:0]    addr_d, addr_q;
    logic             rvalid_d, rvalid_q, hvalid_d, hvalid_q;
    logic             rd_valid_d, rd_valid_q, rdv_d, rdv_q;
    logic [PIX_W-1:0] pix_d, pix_q;
    logic             unused_bits;

`ifdef SNAKE_SPRITE_ORIENT_EN
    snake_sprite_orient #(.CW(CW)) u_orient (
        .x      (rd_x),
        .y      (rd_y),
        .orient (rd_orient),
        .sx     (sx),
        .sy     (sy)
    );
    assign unused_bits = ^{render_wide[31:AW], INIT_FILE != ""};
`else
    assign sx = rd_x;
    assign sy = rd_y;
    assign unused_bits = ^{render_wide[31:AW], rd_orient, INIT_FILE != ""};
`endif

    // Renderer owns the shared read port whenever it requests; host reads wait
    always_comb begin
        render_wide = sprite_addr(32'(rd_sprite), 32'(sx), 32'(sy), CW);
        addr_d      = rd_req ? render_wide[AW-1:0] : address;
        rvalid_d    = rd_req;
        hvalid_d    = chipselect & read & ~rd_req;
        pix_d       = (rvalid_q | hvalid_q) ? mem[addr_q] : pix_q;
        rd_valid_d  = rvalid_q;
        rdv_d       = hvalid_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            rvalid_q   <= 1'b0;
            hvalid_q   <= 1'b0;
            pix_q      <= '0;
            rd_valid_q <= 1'b0;
            rdv_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rvalid_q   <= rvalid_d;
            hvalid_q   <= hvalid_d;
            pix_q      <= pix_d;
            rd_valid_q <= rd_valid_d;
            rdv_q      <= rdv_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BW; i++)
            if (chipselect && write && byteenable[i]) mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
    end

    assign waitrequest   = chipselect & read & rd_req;
    assign rd_valid      = rd_valid_q;
    assign rd_pixel      = pix_q;
    assign rd_opaque     = rd_valid_q & (pix_q != TRANSPARENT);
    assign readdatavalid = rdv_q;
    assign readdata      = pix_q;
endmodule
